// File: rtl/conv_sequencer.sv
// Control FSM for the image-convolution datapath: key latch, kernel load, then per-pixel window gather, MAC and write.
// Optional CONV_PIX_COUNT_EN adds a saturating pix_count output of pixels written in the current frame.
module conv_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_pressed,
    input  logic        abort,
    input  logic        ker_final_addr,
    input  logic        nine_flag,
    input  logic        sum_flag,
    input  logic        pix_final_addr,
    output logic        en_key,
    output logic        s_key,
    output logic        en_ker_addr,
    output logic        s_ker_addr,
    output logic        en_inc_ker,
    output logic        s_inc_ker,
    output logic        en_load_nine,
    output logic        s_load_nine,
    output logic        en_inc_nine,
    output logic        s_inc_nine,
    output logic        en_rst_nine,
    output logic        en_inc_pix,
    output logic        s_inc_pix,
    output logic        en_rst_inc_pix,
    output logic        en_read_pix,
    output logic        s_read_pix,
    output logic        en_apply_ker,
    output logic        s_apply_ker,
    output logic        en_inc_sum,
    output logic        s_inc_sum,
    output logic        en_rst_sumnine,
    output logic        en_divide_ker,
    output logic        s_divide_ker,
    output logic        busy,
    output logic        done,
`ifdef CONV_PIX_COUNT_EN
    output logic [14:0] pix_count,
`endif
    output logic [3:0]  dbg_state
);

    // key_valid is a one-cycle strobe with no ready: it is taken only in IDLE, otherwise dropped.
    typedef enum logic [3:0] {
        S_IDLE, S_KEY, S_KCLR, S_KWAIT, S_KCAP, S_WSET, S_WWAIT,
        S_WCAP, S_SUM, S_WR1, S_WR2, S_NEXT, S_FIN
    } state_t;

    localparam logic [1:0]  LAST_WAIT = 2'(MEM_LAT - 1);

    state_t     state;
    state_t     next_state;
    logic [1:0] wait_cnt;
    logic       wait_done;

    function automatic logic is_conv_key(input logic [7:0] code);
        case (code)
            8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24: is_conv_key = 1'b1;
            default:                                  is_conv_key = 1'b0;
        endcase
    endfunction

    assign wait_done = (wait_cnt == LAST_WAIT);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if ((state == S_KWAIT || state == S_WWAIT) && next_state == state)
                wait_cnt <= wait_cnt + 2'd1;
            else
                wait_cnt <= 2'd0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (key_valid && is_conv_key(key_pressed)) next_state = S_KEY;
            S_KEY:   next_state = S_KCLR;
            S_KCLR:  next_state = S_KWAIT;
            // The address incremented by the last capture is visible on the first wait cycle.
            S_KWAIT: begin
                if (wait_cnt == 2'd0 && ker_final_addr) next_state = S_WSET;
                else if (wait_done)                     next_state = S_KCAP;
            end
            S_KCAP:  next_state = S_KWAIT;
            S_WSET:  next_state = S_WWAIT;
            S_WWAIT: if (wait_done) next_state = S_WCAP;
            S_WCAP:  next_state = nine_flag ? S_SUM : S_WWAIT;
            S_SUM:   if (sum_flag) next_state = S_WR1;
            S_WR1:   next_state = S_WR2;
            S_WR2:   next_state = S_NEXT;
            S_NEXT:  next_state = pix_final_addr ? S_FIN : S_WSET;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    always_comb begin
        en_key = 1'b0;         s_key = 1'b0;
        en_ker_addr = 1'b0;    s_ker_addr = 1'b0;
        en_inc_ker = 1'b0;     s_inc_ker = 1'b0;
        en_load_nine = 1'b0;   s_load_nine = 1'b0;
        en_inc_nine = 1'b0;    s_inc_nine = 1'b0;    en_rst_nine = 1'b0;
        en_inc_pix = 1'b0;     s_inc_pix = 1'b0;     en_rst_inc_pix = 1'b0;
        en_read_pix = 1'b0;    s_read_pix = 1'b0;
        en_apply_ker = 1'b0;   s_apply_ker = 1'b0;
        en_inc_sum = 1'b0;     s_inc_sum = 1'b0;     en_rst_sumnine = 1'b0;
        en_divide_ker = 1'b0;  s_divide_ker = 1'b0;
        done = 1'b0;
        busy = (state != S_IDLE);
        case (state)
            S_KEY: begin
                en_key = 1'b1; s_key = 1'b1;
            end
            S_KCLR: begin
                en_inc_ker = 1'b1;
                en_read_pix = 1'b1;
                en_apply_ker = 1'b1;
            end
            S_KCAP: begin
                en_ker_addr = 1'b1; s_ker_addr = 1'b1;
                en_inc_ker = 1'b1;  s_inc_ker = 1'b1;
            end
            S_WSET: begin
                en_rst_nine = 1'b1; en_rst_inc_pix = 1'b1; en_rst_sumnine = 1'b1;
                en_apply_ker = 1'b1;
            end
            S_WCAP: begin
                en_load_nine = 1'b1; s_load_nine = 1'b1;
                en_inc_nine = 1'b1;  s_inc_nine = 1'b1;
                en_inc_pix = 1'b1;   s_inc_pix = 1'b1;
            end
            S_SUM: begin
                en_apply_ker = 1'b1; s_apply_ker = 1'b1;
                en_inc_sum = 1'b1;   s_inc_sum = 1'b1;
            end
            S_WR1: begin
                en_divide_ker = 1'b1; s_divide_ker = 1'b1;
            end
            S_WR2: en_divide_ker = 1'b1;
            S_NEXT: begin
                if (!pix_final_addr) begin
                    en_read_pix = 1'b1; s_read_pix = 1'b1;
                end
            end
            S_FIN: done = 1'b1;
            default: ;
        endcase
    end

`ifdef CONV_PIX_COUNT_EN
    localparam logic [14:0] PIX_MAX = 15'd19200;

    always_ff @(posedge clk) begin
        if (rst)
            pix_count <= 15'd0;
        else if (state == S_KCLR)
            pix_count <= 15'd0;
        else if (state == S_WR1 && pix_count != PIX_MAX)
            pix_count <= pix_count + 15'd1;
    end
`endif

endmodule
